// File: rtl/rand_stream_mst.sv
// -----------------------------------------------------------------------------
// rand_stream_mst
//
// Randomizing stream master for benches. A stimulus process pushes values into
// an internal FIFO; the block replays them on a valid/ready output stream,
// inserting a random number of idle cycles (drawn uniformly from
// [MinWaitCycles, MaxWaitCycles]) before each valid assertion. hold_i stalls
// the start of a new transfer but never retracts a valid that is already up.
//
// Handshake semantics (both the push side and the output side):
//   A beat transfers at a rising clk_i edge where valid and ready are both 1.
//   Once valid_o is 1 it stays 1, and data_o stays constant, until the edge
//   at which ready_i is sampled 1. push_ready_o depends only on the
//   registered FIFO count, never on the same-cycle pop.
//
// Parameters:
//   T              payload type
//   Depth          FIFO entries (>= 1)
//   MinWaitCycles  minimum idle cycles before each valid assertion
//   MaxWaitCycles  maximum idle cycles (>= MinWaitCycles)
//   ApplDelay      edge-to-output delay; this synthesizable body updates its
//                  outputs on the edge itself, so only 0 is accepted here
//
// Ports:
//   clk_i         in   clock, rising edge active
//   rst_ni        in   asynchronous active-low reset (flushes FIFO, idles FSM)
//   hold_i        in   blocks the start of a new transfer
//   push_valid_i  in   stimulus offers push_data_i
//   push_data_i   in   value to enqueue
//   push_ready_o  out  FIFO not full
//   valid_o       out  stream valid
//   data_o        out  stream payload
//   ready_i       in   sink ready
//   fill_o        out  FIFO occupancy
//   idle_o        out  FIFO empty and valid_o low
//   dbg_state_o   out  output FSM state (0 IDLE, 1 WAIT, 2 VALID)
//
// Configuration macro:
//   RAND_STREAM_MST_ASSERT_EN  compiles in the protocol/sanity assertions.
// -----------------------------------------------------------------------------
module rand_stream_mst #(
    parameter type         T             = logic,
    parameter int unsigned Depth         = 4,
    parameter int unsigned MinWaitCycles = 0,
    parameter int unsigned MaxWaitCycles = 0,
    parameter int unsigned ApplDelay     = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       hold_i,
    input  logic                       push_valid_i,
    input  T                           push_data_i,
    output logic                       push_ready_o,
    output logic                       valid_o,
    output T                           data_o,
    input  logic                       ready_i,
    output logic [$clog2(Depth+1)-1:0] fill_o,
    output logic                       idle_o,
    output logic [1:0]                 dbg_state_o
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (Depth < 1) begin : g_bad_depth
        $fatal(1, "rand_stream_mst: Depth must be at least 1");
    end
    if (MaxWaitCycles < MinWaitCycles) begin : g_bad_wait
        $fatal(1, "rand_stream_mst: MaxWaitCycles must be >= MinWaitCycles");
    end
    if (ApplDelay != 0) begin : g_bad_delay
        $fatal(1, "rand_stream_mst: only ApplDelay == 0 is supported");
    end

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    localparam int unsigned FillW = $clog2(Depth + 1);
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW  = (MaxWaitCycles > 0) ? $clog2(MaxWaitCycles + 1) : 1;

    localparam logic [FillW-1:0] DEPTH_F  = FillW'(Depth);
    localparam logic [PtrW-1:0]  PTR_LAST = PtrW'(Depth - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    T                 mem [Depth];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [FillW-1:0] count;

    state_t           state;
    logic [CntW-1:0]  cnt;      // remaining idle cycles while in S_WAIT
    logic [CntW-1:0]  n_draw;   // wait length for the next launch
    logic             valid_q;
    T                 data_q;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Pointer increment with wrap at Depth (Depth need not be a power of 2).
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PtrW'(1);
    endfunction

    // Uniform draw of a wait length in [MinWaitCycles, MaxWaitCycles].
    function automatic logic [CntW-1:0] draw_wait();
        int unsigned n;
        n = $urandom_range(MaxWaitCycles, MinWaitCycles);
        return CntW'(n);
    endfunction

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic push_fire;
    logic pop_fire;
    logic start_idle;
    logic start_next;
    logic launch;
    logic wait_done;
    T     launch_head;

    // Full is judged on the registered count only: a pop at the same edge
    // does not make room for a push at that edge.
    assign push_ready_o = (count < DEPTH_F);
    assign push_fire    = push_valid_i && push_ready_o;
    assign pop_fire     = valid_q && ready_i;

    // A new transfer starts either from IDLE, or straight out of VALID when
    // at least one entry remains behind the one being popped. A push at the
    // same edge is not counted, so count must already be 2 or more.
    assign start_idle = (state == S_IDLE) && (count != '0) && !hold_i;
    assign start_next = (state == S_VALID) && ready_i && (count > FillW'(1)) && !hold_i;
    assign launch     = start_idle || start_next;

    // When chaining out of VALID, the current head is leaving this edge, so
    // the next payload is the entry behind it.
    assign launch_head = start_next ? mem[ptr_inc(rd_ptr)] : mem[rd_ptr];

    assign wait_done = (state == S_WAIT) && !hold_i && (cnt == CntW'(1));

    // -------------------------------------------------------------------------
    // FIFO storage (contents need no reset; the pointers define validity)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + FillW'(1);
                2'b01:   count <= count - FillW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output FSM
    //
    // The wait length used at a launch is drawn ahead of time and replenished
    // at every launch, so each launch consumes one independent uniform draw.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            cnt     <= '0;
            n_draw  <= draw_wait();
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (launch) begin
            n_draw <= draw_wait();
            if (n_draw == '0) begin
                state   <= S_VALID;
                valid_q <= 1'b1;
                data_q  <= launch_head;
            end else begin
                state   <= S_WAIT;
                cnt     <= n_draw;
                valid_q <= 1'b0;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    // hold_i freezes the countdown
                    if (wait_done) begin
                        state   <= S_VALID;
                        valid_q <= 1'b1;
                        data_q  <= mem[rd_ptr];
                    end else if (!hold_i) begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                S_VALID: begin
                    // Reaching here with ready_i means no chained launch:
                    // either the FIFO drains or hold_i is up.
                    if (ready_i) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign fill_o      = count;
    assign idle_o      = (count == '0) && !valid_q;
    assign dbg_state_o = state;

    // -------------------------------------------------------------------------
    // Assertions
    // -------------------------------------------------------------------------
`ifdef RAND_STREAM_MST_ASSERT_EN
    a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o)))
        else $error("rand_stream_mst: valid_o/data_o changed while stalled");

    a_fill_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fill_o <= DEPTH_F))
        else $error("rand_stream_mst: fill_o exceeds Depth");

    a_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_valid_i |-> push_ready_o))
        else $error("rand_stream_mst: push attempted while FIFO full");

    a_known_ctrl : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({ready_i, hold_i}))
        else $error("rand_stream_mst: unknown value on ready_i or hold_i");
`else
    // Checker-free build: behaviour is identical, only the assertions are absent.
`endif

endmodule

// File: tb/tb_rand_stream_mst.sv
// -----------------------------------------------------------------------------
// tb_rand_stream_mst
//
// Two instances of rand_stream_mst (Depth=4, 8-bit payload):
//   u_dut0 : MinWaitCycles = MaxWaitCycles = 0
//   u_dut3 : MinWaitCycles = MaxWaitCycles = 3
// Inputs are driven 1 time unit after the rising edge; outputs are checked at
// that point (after the edge) or on the falling edge by the scoreboards.
// -----------------------------------------------------------------------------
module tb_rand_stream_mst;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic rst_n0 = 1'b1;
    logic rst_n3 = 1'b1;

    // -------------------------------------------------------------------------
    // DUT signals
    // -------------------------------------------------------------------------
    logic       hold0 = 1'b0, pv0 = 1'b0, rdy0 = 1'b0;
    logic [7:0] pd0 = 8'h00;
    logic       pr0, valid0, idle0;
    logic [7:0] data0;
    logic [2:0] fill0;
    logic [1:0] st0;

    logic       hold3 = 1'b0, pv3 = 1'b0, rdy3 = 1'b0;
    logic [7:0] pd3 = 8'h00;
    logic       pr3, valid3, idle3;
    logic [7:0] data3;
    logic [2:0] fill3;
    logic [1:0] st3;

    rand_stream_mst #(
        .T(logic [7:0]), .Depth(4), .MinWaitCycles(0), .MaxWaitCycles(0), .ApplDelay(0)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n0), .hold_i(hold0),
        .push_valid_i(pv0), .push_data_i(pd0), .push_ready_o(pr0),
        .valid_o(valid0), .data_o(data0), .ready_i(rdy0),
        .fill_o(fill0), .idle_o(idle0), .dbg_state_o(st0)
    );

    rand_stream_mst #(
        .T(logic [7:0]), .Depth(4), .MinWaitCycles(3), .MaxWaitCycles(3), .ApplDelay(0)
    ) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n3), .hold_i(hold3),
        .push_valid_i(pv3), .push_data_i(pd3), .push_ready_o(pr3),
        .valid_o(valid3), .data_o(data3), .ready_i(rdy3),
        .fill_o(fill3), .idle_o(idle3), .dbg_state_o(st3)
    );

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Scoreboards: accepted pushes are queued, every transfer pops one entry
    // -------------------------------------------------------------------------
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q3[$];
    int xfer_n0 = 0;
    int first0  = 0;
    int last0   = 0;

    always @(negedge clk) begin
        if (rst_n0) begin
            if (valid0 && rdy0) begin
                if (exp_q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out0_unexpected: got %0h expected no transfer", data0);
                end else begin
                    check("out0_data", data0, exp_q0.pop_front());
                end
                if (xfer_n0 == 0) first0 = cyc;
                last0 = cyc;
                xfer_n0++;
            end
            if (pv0 && pr0) exp_q0.push_back(pd0);
        end
    end

    always @(negedge clk) begin
        if (rst_n3) begin
            if (valid3 && rdy3) begin
                if (exp_q3.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out3_unexpected: got %0h expected no transfer", data3);
                end else begin
                    check("out3_data", data3, exp_q3.pop_front());
                end
            end
            if (pv3 && pr3) exp_q3.push_back(pd3);
        end
    end

    // -------------------------------------------------------------------------
    // Vector table for u_dut0: inputs applied before an edge, outputs expected
    // after it. Data is only compared when valid is expected high.
    // -------------------------------------------------------------------------
    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       rdy;
        logic       hold;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ef;
        logic       epr;
        logic       eidle;
    } vec_t;

    vec_t tbl[19];

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0,  1'b0, 8'h00, 3'd1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0,  1'b1, 8'h11, 3'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0,  1'b1, 8'h11, 3'd3, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0,  1'b1, 8'h11, 3'd4, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h55, 1'b1, 1'b0,  1'b1, 8'h22, 3'd3, 1'b1, 1'b0}; // push refused at full
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b0,  1'b1, 8'h22, 3'd4, 1'b0, 1'b0}; // retried push lands
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1,  1'b0, 8'h00, 3'd3, 1'b1, 1'b0}; // pop, hold -> idle
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1,  1'b0, 8'h00, 3'd3, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0,  1'b1, 8'h33, 3'd3, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1,  1'b1, 8'h33, 3'd3, 1'b1, 1'b0}; // hold keeps valid
        tbl[10] = '{1'b1, 8'h66, 1'b1, 1'b0,  1'b1, 8'h44, 3'd3, 1'b1, 1'b0}; // push+pop
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h55, 3'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h66, 3'd1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 8'h00, 3'd0, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 8'h77, 1'b1, 1'b0,  1'b0, 8'h00, 3'd1, 1'b1, 1'b0}; // no bypass
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h77, 3'd1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 8'h88, 1'b1, 1'b0,  1'b0, 8'h00, 3'd1, 1'b1, 1'b0}; // same-edge push not chained
        tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0,  1'b1, 8'h88, 3'd1, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0,  1'b0, 8'h00, 3'd0, 1'b1, 1'b1};

        // ---- reset values, applied asynchronously ----
        #2;
        rst_n0 = 1'b0;
        rst_n3 = 1'b0;
        #1;
        check("rst0_valid", valid0, 1'b0);
        check("rst0_data",  data0,  8'h00);
        check("rst0_fill",  fill0,  3'd0);
        check("rst0_pready", pr0,   1'b1);
        check("rst0_idle",  idle0,  1'b1);
        check("rst3_valid", valid3, 1'b0);
        check("rst3_fill",  fill3,  3'd0);
        check("rst3_idle",  idle3,  1'b1);
        repeat (2) step();
        rst_n0 = 1'b1;
        rst_n3 = 1'b1;
        step();
        check("post_rst_idle", idle0, 1'b1);

        // ---- table-driven sequence on u_dut0 ----
        for (int i = 0; i < 19; i++) begin
            pv0   = tbl[i].pv;
            pd0   = tbl[i].pd;
            rdy0  = tbl[i].rdy;
            hold0 = tbl[i].hold;
            step();
            check($sformatf("tbl%0d_valid", i), valid0, tbl[i].ev);
            if (tbl[i].ev) check($sformatf("tbl%0d_data", i), data0, tbl[i].ed);
            check($sformatf("tbl%0d_fill", i), fill0, tbl[i].ef);
            check($sformatf("tbl%0d_pready", i), pr0, tbl[i].epr);
            check($sformatf("tbl%0d_idle", i), idle0, tbl[i].eidle);
        end
        pv0 = 1'b0;
        rdy0 = 1'b0;
        hold0 = 1'b0;

        // ---- throughput: 8 back-to-back pushes, ready high ----
        xfer_n0 = 0;
        rdy0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pv0 = 1'b1;
            pd0 = 8'(i);
            step();
            check("tput_pready", pr0, 1'b1);
        end
        pv0 = 1'b0;
        repeat (4) step();
        check("tput_count", xfer_n0, 8);
        check("tput_span", last0 - first0, 7);
        check("tput_idle", idle0, 1'b1);
        rdy0 = 1'b0;

        // ---- stall: ready low for 5 cycles with data 0x3C ----
        pv0 = 1'b1;
        pd0 = 8'h3C;
        step();
        pv0 = 1'b0;
        step();
        check("stall_valid0", valid0, 1'b1);
        check("stall_data0", data0, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", valid0, 1'b1);
            check("stall_data", data0, 8'h3C);
        end
        rdy0 = 1'b1;
        step();
        check("stall_done_valid", valid0, 1'b0);
        check("stall_done_idle", idle0, 1'b1);
        rdy0 = 1'b0;

        // ---- latency with Min=Max=3: valid 4 edges after the push edge ----
        pv3 = 1'b1;
        pd3 = 8'hA5;
        step();
        pv3 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("lat_low%0d", i), valid3, 1'b0);
        end
        step();
        check("lat_valid", valid3, 1'b1);
        check("lat_data", data3, 8'hA5);
        rdy3 = 1'b1;
        step();
        check("lat_done", valid3, 1'b0);
        rdy3 = 1'b0;

        // ---- hold: 10 cycles with data queued, then release ----
        hold3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pv3 = (i < 2);
            pd3 = (i == 0) ? 8'h10 : 8'h20;
            step();
            check("hold_low", valid3, 1'b0);
        end
        pv3 = 1'b0;
        check("hold_fill", fill3, 3'd2);
        hold3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rel_wait", valid3, 1'b0);
        end
        step();
        check("hold_rel_valid", valid3, 1'b1);
        check("hold_rel_data", data3, 8'h10);
        hold3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_keep_valid", valid3, 1'b1);
            check("hold_keep_data", data3, 8'h10);
        end
        rdy3 = 1'b1;
        step();
        check("hold_xfer_valid", valid3, 1'b0);
        check("hold_xfer_fill", fill3, 3'd1);
        step();
        check("hold_still_low", valid3, 1'b0);
        hold3 = 1'b0;
        repeat (5) step();
        check("hold_drain_idle", idle3, 1'b1);
        rdy3 = 1'b0;

        // ---- asynchronous reset mid-WAIT with fill 3 ----
        for (int i = 0; i < 3; i++) begin
            pv3 = 1'b1;
            pd3 = 8'(i + 1);
            step();
        end
        pv3 = 1'b0;
        check("mid_fill", fill3, 3'd3);
        check("mid_state_wait", st3, 2'd1);
        #1;
        rst_n3 = 1'b0;
        #1;
        check("arst_valid", valid3, 1'b0);
        check("arst_fill", fill3, 3'd0);
        check("arst_pready", pr3, 1'b1);
        check("arst_idle", idle3, 1'b1);
        exp_q3.delete();
        step();
        check("arst_hold_fill", fill3, 3'd0);
        rst_n3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("arst_after_valid", valid3, 1'b0);
            check("arst_after_idle", idle3, 1'b1);
        end

        // ---- everything pushed was delivered ----
        check("q0_empty", exp_q0.size(), 0);
        check("q3_empty", exp_q3.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time so the bench always terminates.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
